// File: rtl/coin_change_dispenser.sv
// coin_change_dispenser: greedy coin change payout from a four-denomination inventory
//
// Ports:
//   clk, reset (async, active-low)
//   abort                      - only when COIN_DISP_ABORT_EN is defined; stops a payout early
//   req_valid/req_amount/req_ready - change request handshake (ready only in IDLE)
//   load/load_type/load_count  - inventory refill, honoured only in IDLE, saturating
//   coin_eject/coin_type       - one-cycle eject pulse and its denomination (00=1,01=2,10=5,11=10)
//   busy, done                 - not-idle flag, one-cycle completion pulse
//   shortfall, error           - undispensed remainder and its nonzero flag, valid from done
//   *_rupee_count              - live inventory per denomination
//
// Optional feature macro: COIN_DISP_ABORT_EN
module coin_change_dispenser #(
    parameter int VALUE_W   = 16,
    parameter int CNT_W     = 8,
    parameter int EJECT_GAP = 2
) (
    input  logic               clk,
    input  logic               reset,
`ifdef COIN_DISP_ABORT_EN
    input  logic               abort,
`endif
    input  logic               req_valid,
    input  logic [VALUE_W-1:0] req_amount,
    output logic               req_ready,
    input  logic               load,
    input  logic [1:0]         load_type,
    input  logic [CNT_W-1:0]   load_count,
    output logic               coin_eject,
    output logic [1:0]         coin_type,
    output logic               busy,
    output logic               done,
    output logic [VALUE_W-1:0] shortfall,
    output logic               error,
    output logic [CNT_W-1:0]   one_rupee_count,
    output logic [CNT_W-1:0]   two_rupee_count,
    output logic [CNT_W-1:0]   five_rupee_count,
    output logic [CNT_W-1:0]   ten_rupee_count
);
    typedef enum logic [2:0] {IDLE, SELECT, EJECT, GAP, DONE} state_t;
    localparam int GW = EJECT_GAP > 1 ? $clog2(EJECT_GAP) : 1;
    localparam logic [VALUE_W-1:0] V1 = VALUE_W'(1);
    localparam logic [VALUE_W-1:0] V2 = VALUE_W'(2);
    localparam logic [VALUE_W-1:0] V5 = VALUE_W'(5);
    localparam logic [VALUE_W-1:0] V10 = VALUE_W'(10);

    state_t             state, next;
    logic [VALUE_W-1:0] remaining;
    logic [CNT_W-1:0]   cnt [4];
    logic [GW-1:0]      gap_cnt;
    logic [3:0]         has;
    logic               found;
    logic [1:0]         pick;
    logic [VALUE_W-1:0] coin_val;
    logic [CNT_W:0]     sum;
    logic               stop;

    assign has[3]   = remaining >= V10 && cnt[3] != '0;
    assign has[2]   = remaining >= V5 && cnt[2] != '0;
    assign has[1]   = remaining >= V2 && cnt[1] != '0;
    assign has[0]   = remaining >= V1 && cnt[0] != '0;
    assign found    = |has;
    assign pick     = has[3] ? 2'd3 : has[2] ? 2'd2 : has[1] ? 2'd1 : 2'd0;
    assign coin_val = coin_type == 2'd3 ? V10 : coin_type == 2'd2 ? V5 : coin_type == 2'd1 ? V2 : V1;
    assign sum      = {1'b0, cnt[load_type]} + {1'b0, load_count};

`ifdef COIN_DISP_ABORT_EN
    // An abort seen during an eject is remembered so the eject still completes.
    logic abort_pend;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            abort_pend <= 1'b0;
        else if (state == EJECT && abort)
            abort_pend <= 1'b1;
        else if (state == DONE)
            abort_pend <= 1'b0;
    end
    assign stop = (state == SELECT || state == GAP) && (abort || abort_pend);
`else
    assign stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = req_valid ? SELECT : IDLE;
            SELECT:  next = (stop || !found) ? DONE : EJECT;
            EJECT:   next = EJECT_GAP == 0 ? SELECT : GAP;
            GAP:     next = stop ? DONE : gap_cnt == '0 ? SELECT : GAP;
            DONE:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining <= '0;
            cnt       <= '{default: '0};
            gap_cnt   <= '0;
            coin_type <= 2'd0;
            shortfall <= '0;
            error     <= 1'b0;
        end else begin
            if (state == IDLE && load)
                cnt[load_type] <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            if (state == IDLE && req_valid)
                remaining <= req_amount;
            // coin_type only moves on the edge into EJECT, so it holds between pulses
            if (next == EJECT)
                coin_type <= pick;
            if (state == EJECT) begin
                cnt[coin_type] <= cnt[coin_type] - 1'b1;
                remaining      <= remaining - coin_val;
                gap_cnt        <= GW'(EJECT_GAP - 1);
            end
            if (state == GAP)
                gap_cnt <= gap_cnt - 1'b1;
            if (next == DONE) begin
                shortfall <= remaining;
                error     <= remaining != '0 || stop;
            end
        end
    end

    assign req_ready        = state == IDLE;
    assign busy             = state != IDLE;
    assign coin_eject       = state == EJECT;
    assign done             = state == DONE;
    assign one_rupee_count  = cnt[0];
    assign two_rupee_count  = cnt[1];
    assign five_rupee_count = cnt[2];
    assign ten_rupee_count  = cnt[3];
endmodule

// File: tb/tb_coin_change_dispenser.sv
// tb_coin_change_dispenser: directed self-checking bench for coin_change_dispenser
module tb_coin_change_dispenser;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        abort = 1'b0;
    logic        req_valid = 1'b0;
    logic [15:0] req_amount = '0;
    logic        req_ready;
    logic        load = 1'b0;
    logic [1:0]  load_type = '0;
    logic [7:0]  load_count = '0;
    logic        coin_eject;
    logic [1:0]  coin_type;
    logic        busy, done, error;
    logic [15:0] shortfall;
    logic [7:0]  c1, c2, c5, c10;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    coin_change_dispenser dut (
        .clk(clk),
        .reset(reset),
`ifdef COIN_DISP_ABORT_EN
        .abort(abort),
`endif
        .req_valid(req_valid),
        .req_amount(req_amount),
        .req_ready(req_ready),
        .load(load),
        .load_type(load_type),
        .load_count(load_count),
        .coin_eject(coin_eject),
        .coin_type(coin_type),
        .busy(busy),
        .done(done),
        .shortfall(shortfall),
        .error(error),
        .one_rupee_count(c1),
        .two_rupee_count(c2),
        .five_rupee_count(c5),
        .ten_rupee_count(c10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_load(input logic [1:0] t, input logic [7:0] n);
        load = 1'b1;
        load_type = t;
        load_count = n;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic request(input logic [15:0] amt);
        req_valid = 1'b1;
        req_amount = amt;
        @(negedge clk);
        req_valid = 1'b0;
        req_amount = 16'hFFFF;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Cycle i after accept: ejects expected at i = 2, 6, 10, ... up to last_ej,
    // eject number e carries type types[2e+1:2e]; done expected at cycle n when fin.
    task automatic watch(input int n, input int last_ej, input logic [31:0] types, input bit fin);
        int e = 0;
        for (int i = 1; i <= n; i++) begin
            bit ej;
            if (i > 1) @(negedge clk);
            ej = i >= 2 && (i - 2) % 4 == 0 && i <= last_ej;
            chk($sformatf("eject@%0d", i), coin_eject, ej);
            chk($sformatf("busy@%0d", i), busy, 1);
            chk($sformatf("done@%0d", i), done, fin && i == n);
            if (ej) begin
                chk($sformatf("type@%0d", i), coin_type, types[2*e+:2]);
                e++;
            end
        end
    endtask

    initial begin
        #3 reset = 1'b0;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_eject", coin_eject, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error, 0);
        chk("rst_short", shortfall, 0);
        chk("rst_type", coin_type, 0);
        chk("rst_cnt", {c1, c2, c5, c10}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 18 from five of each: 10, 5, 2, 1
        for (int t = 0; t < 4; t++) do_load(2'(t), 8'd5);
        chk("load5", {c1, c2, c5, c10}, 32'h05050505);
        request(16'd18);
        chk("ready_busy", req_ready, 0);
        watch(18, 14, 32'h1B, 1);
        chk("t1_short", shortfall, 0);
        chk("t1_err", error, 0);
        chk("t1_cnt", {c1, c2, c5, c10}, 32'h04040404);
        @(negedge clk);
        chk("t1_ready", req_ready, 1);
        chk("t1_done_pulse", done, 0);

        // only tens, request 7, load and accept in the same cycle
        do_reset();
        load = 1'b1; load_type = 2'd3; load_count = 8'd3;
        request(16'd7);
        load = 1'b0;
        watch(2, 0, 0, 1);
        chk("t2_short", shortfall, 7);
        chk("t2_err", error, 1);
        chk("t2_ten", c10, 3);
        @(negedge clk);

        // zero amount finishes in cycle k+2 with no ejects
        request(16'd0);
        watch(2, 0, 0, 1);
        chk("t0_short", shortfall, 0);
        chk("t0_err", error, 0);
        @(negedge clk);

        // greedy shortfall: 5, 5, then ten 1s, 3 left
        do_reset();
        do_load(2'd2, 8'd2);
        do_load(2'd0, 8'd10);
        request(16'd23);
        watch(50, 46, 32'hA, 1);
        chk("t3_short", shortfall, 3);
        chk("t3_err", error, 1);
        chk("t3_cnt", {c1, c2, c5, c10}, 0);
        @(negedge clk);

        // saturation and load ignored while busy
        do_load(2'd0, 8'd250);
        do_load(2'd0, 8'd10);
        chk("sat255", c1, 255);
        do_load(2'd0, 8'd1);
        chk("sat_hold", c1, 255);
        request(16'd1);
        load = 1'b1; load_type = 2'd1; load_count = 8'd7;
        watch(6, 2, 0, 1);
        load = 1'b0;
        chk("busy_load_two", c2, 0);
        chk("busy_load_one", c1, 254);
        @(negedge clk);

        // reset in the middle of a payout
        do_load(2'd3, 8'd5);
        request(16'd30);
        watch(7, 6, 32'hF, 0);
        reset = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_ready", req_ready, 1);
        chk("mid_type", coin_type, 0);
        chk("mid_cnt", {c1, c2, c5, c10}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_ready", req_ready, 1);
        chk("post_eject", coin_eject, 0);

`ifdef COIN_DISP_ABORT_EN
        do_load(2'd1, 8'd5);
        request(16'd10);
        watch(7, 6, 32'h5, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_done", done, 1);
        chk("ab_short", shortfall, 6);
        chk("ab_err", error, 1);
        chk("ab_two", c2, 3);
        @(negedge clk);
        chk("ab_ready", req_ready, 1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/coin_change_dispenser.md
# coin_change_dispenser

Dispensing-side counterpart of the coin counter. Holds an inventory of ₹1/₹2/₹5/₹10 coins and accepts a change amount over a valid/ready handshake. Pays the amount out greedily (largest coin first) as a sequence of one-cycle `coin_eject` pulses tagged with `coin_type`, using the same 2-bit coin encoding as the counter. Sits between the vending controller, which requests change, and the physical ejector solenoids.

## Interface
- `VALUE_W`, 16, width of amount and shortfall
- `CNT_W`, 8, width of each inventory counter
- `EJECT_GAP`, 2, idle cycles after each eject pulse (≥0)

- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low; clears all state
- `req_valid` in 1: change request present
- `req_amount` in VALUE_W: rupees to dispense
- `req_ready` out 1: high only in IDLE
- `load` in 1: inventory refill strobe
- `load_type` in 2: 00=₹1, 01=₹2, 10=₹5, 11=₹10
- `load_count` in CNT_W: coins added
- `coin_eject` out 1: one-cycle pulse per ejected coin
- `coin_type` out 2: denomination of current eject; same encoding as `load_type`
- `busy` out 1: high in any state except IDLE
- `done` out 1: one-cycle pulse at request completion
- `shortfall` out VALUE_W: undispensed remainder, valid from `done` until next accept
- `error` out 1: `shortfall != 0`, same validity as `shortfall`
- `one_rupee_count`, `two_rupee_count`, `five_rupee_count`, `ten_rupee_count` out CNT_W each: live inventory
- `abort` in 1: present only with `COIN_DISP_ABORT_EN`

## Operation
- FSM states: IDLE, SELECT, EJECT, GAP, DONE.
- IDLE → SELECT when `req_valid`; `req_amount` latched into `remaining`.
- SELECT: choose the largest denomination with value ≤ `remaining` and count > 0. Go to EJECT if one exists. Go to DONE if none exists or `remaining == 0`.
- EJECT: `coin_eject`=1 and `coin_type`=chosen denomination. That count decrements and `remaining` drops by the coin value (₹1/2/5/10). Then GAP, or SELECT if `EJECT_GAP`=0.
- GAP: wait `EJECT_GAP` cycles, then SELECT.
- DONE: `done`=1; `shortfall` ← `remaining`; `error` ← (`remaining` != 0). Then IDLE.
- Greedy only; no backtracking. If greedy cannot make exact change with the available stock, the result is a shortfall even when some other coin combination would succeed.
- Load is honoured only in IDLE; ignored in every other state. The addition saturates at 2^CNT_W−1.
- Load and accept in the same IDLE cycle: both take effect. The first SELECT sees the post-load counts.
- `coin_type` holds its last value when `coin_eject`=0.
- Reset values: state IDLE, all counts 0, `remaining`/`shortfall` 0, `coin_eject`/`done`/`busy`/`error` 0, `coin_type` 00, `req_ready` 1.
- Reset mid-dispense: immediate return to reset values. A pulse in progress is cut, and inventory is lost (refill required).

## Timing
- All outputs registered, or decoded from registered state only.
- Request accepted at edge k → SELECT in cycle k+1 → first `coin_eject` in cycle k+2.
- Pulse-to-pulse spacing: `EJECT_GAP`+2 cycles.
- Last eject at cycle j → SELECT at j+1+`EJECT_GAP` → `done` one cycle later → `req_ready` high the cycle after `done`.
- Zero amount: `done` in cycle k+2; no ejects.
- `req_amount` is sampled only at accept and may change afterwards.

## Configuration
- `COIN_DISP_ABORT_EN` defined:
  - adds input `abort`;
  - `abort` high in SELECT or GAP → DONE next cycle with `shortfall`=`remaining` and `error`=1;
  - `abort` in EJECT takes effect after that eject completes;
  - `abort` is ignored in IDLE and DONE.
- Macro undefined: no `abort` port; every request runs to completion.

## Test plan
- Load 5 of each coin, request 18 → ejects ₹10, ₹5, ₹2, ₹1 (types 11, 10, 01, 00), 4 cycles apart (`EJECT_GAP`=2). Then `done`, `shortfall`=0, `error`=0, all counts 4.
- Load only 3×₹10, request 7 → no ejects, `done` in cycle k+2, `shortfall`=7, `error`=1, ₹10 count stays 3.
- Load 2×₹5 and 10×₹1, request 23 → ₹5, ₹5, then ₹1 ×10, `shortfall`=3, `error`=1, all counts 0.
- Load 250 ₹1 then 10 ₹1 → count 255. Load asserted while `busy` → count unchanged.
- Request 30 with 5×₹10; drive `reset` low after the second eject → all outputs at reset values within the same cycle, counts 0, `req_ready`=1 after release.
- With `COIN_DISP_ABORT_EN`: 5×₹2 loaded, request 10; `abort` in the GAP after the second eject → `done`, `shortfall`=6, `error`=1, ₹2 count 3.
